process_scheduler: RTL and testbench
====================================

PROCESS_SCHEDULER -- requirements
Module: process_scheduler

Interface
REQ-001 SHALL have port Clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port start, input, 1 bit: one-cycle pulse that begins scheduling from IDLE.
REQ-004 SHALL have port cfg_we, input, 1 bit: context-table write strobe.
REQ-005 SHALL have port cfg_id, input, 3 bits: slot index written.
REQ-006 SHALL have port cfg_pc, input, 32 bits: start PC for the slot.
REQ-007 SHALL have port cfg_valid, input, 1 bit: valid flag for the slot.
REQ-008 SHALL have port quantum, input, 5 bits: instructions per time slice; 0 disables preemption.
REQ-009 SHALL have port proc_done, input, 1 bit: running process finished; its slot is retired.
REQ-010 SHALL have port pc_counter, input, 5 bits: per-slice instruction count from the program counter.
REQ-011 SHALL have port pc_out, input, 32 bits: current PC from the program counter.
REQ-012 SHALL have port change_pc, output, 1 bit: load pc_in into the program counter.
REQ-013 SHALL have port pc_in, output, 32 bits: PC to load.
REQ-014 SHALL have port exec_proc, output, 1 bit: high freezes pc_counter; the scheduler/OS owns the core.
REQ-015 SHALL have port pc_hold, output, 1 bit: drives Halt; freezes the PC during a switch.
REQ-016 SHALL have port cur_proc, output, 3 bits: slot currently loaded.
REQ-017 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-018 SHALL hold an 8-entry context table, each entry {valid, saved_pc[31:0]}.
REQ-019 SHALL implement FSM states IDLE, RUN, SAVE, SELECT, LOAD.
REQ-020 In IDLE: exec_proc=1, pc_hold=1, change_pc=0; on start=1 SHALL go to SELECT.
REQ-021 In RUN: exec_proc=0, pc_hold=0; on proc_done=1 SHALL clear valid[cur_proc] and go to SELECT without saving.
REQ-022 In RUN with proc_done=0, quantum!=0 and pc_counter>=quantum, SHALL go to SAVE.
REQ-023 In SAVE (one cycle, pc_hold=1, exec_proc=1): SHALL write saved_pc[cur_proc]<=pc_out, then go to SELECT.
REQ-024 SELECT (one cycle) SHALL search slots cur_proc+1 .. cur_proc+8, modulo 8, and pick the first valid slot; the current slot is the last candidate.
REQ-025 If no slot is valid, SELECT SHALL go to IDLE and leave cur_proc unchanged.
REQ-026 LOAD (one cycle) SHALL assert change_pc=1 with pc_in=saved_pc[selected], set cur_proc<=selected, then go to RUN.
REQ-027 change_pc SHALL be high only in LOAD, for exactly one cycle per switch.
REQ-028 Switch latency, expiry detect -> first RUN cycle of the new process, SHALL be 3 cycles (SAVE, SELECT, LOAD).
REQ-029 A cfg write SHALL be accepted in any state and SHALL set valid[cfg_id]=cfg_valid and saved_pc[cfg_id]=cfg_pc.
REQ-030 A cfg write in SAVE to slot cur_proc SHALL take priority over the pc_out save.
REQ-031 If a cfg write clears valid of cur_proc during RUN, the block SHALL treat it as proc_done on the next cycle.
REQ-032 proc_done and quantum expiry in the same cycle: proc_done SHALL win.
REQ-033 start outside IDLE SHALL be ignored; proc_done outside RUN SHALL be ignored.
REQ-034 With a single valid slot, expiry SHALL save and reload that same slot (change_pc pulses, pc_in = saved PC).

Reset
REQ-035 Reset=0 SHALL immediately force: state=IDLE; all valid=0; all saved_pc=0; cur_proc=7 (so the first search begins at slot 0); change_pc=0; pc_in=0; exec_proc=1; pc_hold=1; busy=0.
REQ-036 Reset asserted mid-switch SHALL abort the switch with no change_pc pulse; deassertion SHALL be synchronised internally to Clock.

Verification
REQ-037 Scenario: cfg slot0=0x100, slot2=0x200, start -> SELECT picks 0; LOAD gives change_pc=1, pc_in=0x100, cur_proc=0.
REQ-038 Scenario: quantum=4, slot0 running, pc_counter reaches 4 with pc_out=0x104 -> saved_pc[0]=0x104; next LOAD has pc_in=0x200, cur_proc=2; 3-cycle latency.
REQ-039 Scenario: slot2 running, proc_done=1 with expiry in the same cycle -> valid[2]=0, no save, next process is slot 0 at pc_in=0x104.
REQ-040 Scenario: only slot 5 valid, quantum=3 -> repeated switches to slot 5, pc_in equal to each saved pc_out.
REQ-041 Scenario: quantum=0 -> never leaves RUN until proc_done; last proc_done -> IDLE, exec_proc=1, busy=0.
REQ-042 Scenario: Reset pulsed during SELECT -> outputs at reset values at once, table cleared, start required to resume.

Source files
------------

// File: rtl/process_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | process_scheduler                                                      |
// | Round-robin, quantum-preemptive scheduler over an 8-slot context table |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module process_scheduler (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        start,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_id,
    input  logic [31:0] cfg_pc,
    input  logic        cfg_valid,
    input  logic [4:0]  quantum,
    input  logic        proc_done,
    input  logic [4:0]  pc_counter,
    input  logic [31:0] pc_out,
    output logic        change_pc,
    output logic [31:0] pc_in,
    output logic        exec_proc,
    output logic        pc_hold,
    output logic [2:0]  cur_proc,
    output logic        busy
);

    localparam int unsigned NUM_SLOTS = 8;
    localparam int unsigned PC_W      = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_SAVE   = 3'd2,
        ST_SELECT = 3'd3,
        ST_LOAD   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        cur_proc_q, cur_proc_d;
    logic [2:0]        sel_q, sel_d;
    logic [NUM_SLOTS-1:0] valid_q, valid_d;
    logic [PC_W-1:0]   saved_pc_q [NUM_SLOTS];
    logic [PC_W-1:0]   saved_pc_d [NUM_SLOTS];

    logic              rst_meta_q;
    logic              rst_sync_q;
    logic              found;
    logic [2:0]        pick;
    logic [2:0]        idx;

    // Assertion passes straight through; release is retimed to Clock.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    // Round-robin search starting after cur_proc; i == 8 wraps back to cur_proc itself.
    always_comb begin
        found = 1'b0;
        pick  = cur_proc_q;
        idx   = cur_proc_q;
        for (int i = 1; i <= NUM_SLOTS; i++) begin
            idx = cur_proc_q + 3'(i);
            if (!found && valid_q[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_proc_d = cur_proc_q;
        sel_d      = sel_q;
        valid_d    = valid_q;
        saved_pc_d = saved_pc_q;
        change_pc  = 1'b0;
        pc_in      = '0;
        exec_proc  = 1'b1;
        pc_hold    = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_SELECT;
            end
            ST_RUN: begin
                exec_proc = 1'b0;
                pc_hold   = 1'b0;
                // A slot invalidated by a cfg write is retired exactly like proc_done.
                if (proc_done || !valid_q[cur_proc_q]) begin
                    valid_d[cur_proc_q] = 1'b0;
                    state_d             = ST_SELECT;
                end else if ((quantum != 5'd0) && (pc_counter >= quantum)) begin
                    state_d = ST_SAVE;
                end
            end
            ST_SAVE: begin
                saved_pc_d[cur_proc_q] = pc_out;
                state_d                = ST_SELECT;
            end
            ST_SELECT: begin
                if (found) begin
                    sel_d   = pick;
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                change_pc  = 1'b1;
                pc_in      = saved_pc_q[sel_q];
                cur_proc_d = sel_q;
                state_d    = ST_RUN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Applied last so host configuration overrides the SAVE write-back and retirement.
        if (cfg_we) begin
            valid_d[cfg_id]    = cfg_valid;
            saved_pc_d[cfg_id] = cfg_pc;
        end
    end

    always_ff @(posedge Clock or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q    <= ST_IDLE;
            cur_proc_q <= 3'd7;
            sel_q      <= 3'd0;
            valid_q    <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                saved_pc_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cur_proc_q <= cur_proc_d;
            sel_q      <= sel_d;
            valid_q    <= valid_d;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                saved_pc_q[i] <= saved_pc_d[i];
            end
        end
    end

    assign cur_proc = cur_proc_q;
    assign busy     = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_process_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_process_scheduler                                                   |
// | Directed self-checking bench for process_scheduler                     |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_process_scheduler;

    logic        Clock;
    logic        Reset;
    logic        start;
    logic        cfg_we;
    logic [2:0]  cfg_id;
    logic [31:0] cfg_pc;
    logic        cfg_valid;
    logic [4:0]  quantum;
    logic        proc_done;
    logic [4:0]  pc_counter;
    logic [31:0] pc_out;
    logic        change_pc;
    logic [31:0] pc_in;
    logic        exec_proc;
    logic        pc_hold;
    logic [2:0]  cur_proc;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    process_scheduler dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .start      (start),
        .cfg_we     (cfg_we),
        .cfg_id     (cfg_id),
        .cfg_pc     (cfg_pc),
        .cfg_valid  (cfg_valid),
        .quantum    (quantum),
        .proc_done  (proc_done),
        .pc_counter (pc_counter),
        .pc_out     (pc_out),
        .change_pc  (change_pc),
        .pc_in      (pc_in),
        .exec_proc  (exec_proc),
        .pc_hold    (pc_hold),
        .cur_proc   (cur_proc),
        .busy       (busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] id, input logic [31:0] pc, input logic v);
        cfg_we    = 1'b1;
        cfg_id    = id;
        cfg_pc    = pc;
        cfg_valid = v;
        tick();
        cfg_we    = 1'b0;
    endtask

    // Steps until the core is handed back (exec_proc low), bounded to 12 cycles.
    task automatic run_switch(output int lat, output int pulses, output logic [31:0] pc_seen);
        lat     = 0;
        pulses  = 0;
        pc_seen = '0;
        do begin
            tick();
            lat++;
            pc_counter = 5'd0;
            proc_done  = 1'b0;
            if (change_pc === 1'b1) begin
                pulses++;
                pc_seen = pc_in;
            end
        end while (exec_proc !== 1'b0 && lat < 12);
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({change_pc, exec_proc, pc_hold, busy} !== 4'b0110) begin
            n_err++;
            $display("FAIL reset_ctl: got %b expected 0110", {change_pc, exec_proc, pc_hold, busy});
        end
        n_cmp++;
        if (pc_in !== 32'h0) begin
            n_err++;
            $display("FAIL reset_pc_in: got %h expected 00000000", pc_in);
        end
        n_cmp++;
        if (cur_proc !== 3'd7) begin
            n_err++;
            $display("FAIL reset_cur_proc: got %0d expected 7", cur_proc);
        end
        Reset = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({change_pc, exec_proc, pc_hold, busy} !== 4'b0110) begin
            n_err++;
            $display("FAIL idle_after_release: got %b expected 0110", {change_pc, exec_proc, pc_hold, busy});
        end
    endtask

    task automatic test_first_dispatch();
        quantum = 5'd4;
        cfg_write(3'd0, 32'h100, 1'b1);
        cfg_write(3'd2, 32'h200, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if ({change_pc, exec_proc, pc_hold, busy} !== 4'b0111) begin
            n_err++;
            $display("FAIL select_ctl: got %b expected 0111", {change_pc, exec_proc, pc_hold, busy});
        end
        tick();
        n_cmp++;
        if ({change_pc, pc_in} !== {1'b1, 32'h100}) begin
            n_err++;
            $display("FAIL first_load: got change_pc=%b pc_in=%h expected 1/00000100", change_pc, pc_in);
        end
        tick();
        n_cmp++;
        if ({change_pc, exec_proc, pc_hold, busy, cur_proc} !== {4'b0001, 3'd0}) begin
            n_err++;
            $display("FAIL first_run: got ctl=%b cur=%0d expected 0001/0",
                     {change_pc, exec_proc, pc_hold, busy}, cur_proc);
        end
    endtask

    task automatic test_expiry();
        int lat;
        int pulses;
        logic [31:0] seen;
        pc_counter = 5'd3;
        pc_out     = 32'h103;
        tick();
        n_cmp++;
        if (exec_proc !== 1'b0) begin
            n_err++;
            $display("FAIL below_quantum: got exec_proc=%b expected 0", exec_proc);
        end
        pc_counter = 5'd4;
        pc_out     = 32'h104;
        run_switch(lat, pulses, seen);
        n_cmp++;
        if ({lat, pulses, seen, cur_proc} !== {32'd4, 32'd1, 32'h200, 3'd2}) begin
            n_err++;
            $display("FAIL expiry_switch: got lat=%0d pulses=%0d pc_in=%h cur=%0d expected 4/1/00000200/2",
                     lat, pulses, seen, cur_proc);
        end
    endtask

    task automatic test_done_wins();
        int lat;
        int pulses;
        logic [31:0] seen;
        pc_counter = 5'd4;
        pc_out     = 32'h2FF;
        proc_done  = 1'b1;
        run_switch(lat, pulses, seen);
        n_cmp++;
        if ({lat, pulses, seen, cur_proc} !== {32'd3, 32'd1, 32'h104, 3'd0}) begin
            n_err++;
            $display("FAIL done_over_expiry: got lat=%0d pulses=%0d pc_in=%h cur=%0d expected 3/1/00000104/0",
                     lat, pulses, seen, cur_proc);
        end
        // Slot 2 is retired, so slot 0 must reload itself.
        pc_counter = 5'd4;
        pc_out     = 32'h150;
        run_switch(lat, pulses, seen);
        n_cmp++;
        if ({lat, pulses, seen, cur_proc} !== {32'd4, 32'd1, 32'h150, 3'd0}) begin
            n_err++;
            $display("FAIL slot2_retired: got lat=%0d pulses=%0d pc_in=%h cur=%0d expected 4/1/00000150/0",
                     lat, pulses, seen, cur_proc);
        end
    endtask

    task automatic test_cfg_clear_running();
        int lat;
        int pulses;
        logic [31:0] seen;
        pc_counter = 5'd0;
        cfg_write(3'd5, 32'h500, 1'b1);
        cfg_write(3'd0, 32'h0, 1'b0);
        run_switch(lat, pulses, seen);
        n_cmp++;
        if ({lat, pulses, seen, cur_proc} !== {32'd3, 32'd1, 32'h500, 3'd5}) begin
            n_err++;
            $display("FAIL cfg_clear_running: got lat=%0d pulses=%0d pc_in=%h cur=%0d expected 3/1/00000500/5",
                     lat, pulses, seen, cur_proc);
        end
    endtask

    task automatic test_single_slot();
        int lat;
        int pulses;
        logic [31:0] seen;
        logic [31:0] exp_pc;
        quantum = 5'd3;
        for (int k = 0; k < 2; k++) begin
            exp_pc     = 32'h510 + 32'(k * 4);
            pc_counter = 5'd3;
            pc_out     = exp_pc;
            run_switch(lat, pulses, seen);
            n_cmp++;
            if ({lat, pulses, seen, cur_proc} !== {32'd4, 32'd1, exp_pc, 3'd5}) begin
                n_err++;
                $display("FAIL single_slot_%0d: got lat=%0d pulses=%0d pc_in=%h cur=%0d expected 4/1/%h/5",
                         k, lat, pulses, seen, cur_proc, exp_pc);
            end
        end
        pc_counter = 5'd3;
        pc_out     = 32'h5AA;
        tick();
        pc_counter = 5'd0;
        cfg_we     = 1'b1;
        cfg_id     = 3'd5;
        cfg_pc     = 32'h777;
        cfg_valid  = 1'b1;
        tick();
        cfg_we = 1'b0;
        tick();
        n_cmp++;
        if ({change_pc, pc_in} !== {1'b1, 32'h777}) begin
            n_err++;
            $display("FAIL cfg_beats_save: got change_pc=%b pc_in=%h expected 1/00000777", change_pc, pc_in);
        end
        tick();
    endtask

    task automatic test_quantum_zero();
        logic stayed;
        quantum    = 5'd0;
        pc_counter = 5'd31;
        stayed     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            start = (i == 3);
            tick();
            if (exec_proc !== 1'b0 || busy !== 1'b1 || change_pc !== 1'b0) stayed = 1'b0;
        end
        start = 1'b0;
        n_cmp++;
        if (stayed !== 1'b1) begin
            n_err++;
            $display("FAIL quantum_zero_stays: got stayed=%b expected 1", stayed);
        end
        proc_done = 1'b1;
        tick();
        proc_done  = 1'b0;
        pc_counter = 5'd0;
        tick();
        n_cmp++;
        if ({change_pc, exec_proc, pc_hold, busy} !== 4'b0110) begin
            n_err++;
            $display("FAIL last_done_idle: got %b expected 0110", {change_pc, exec_proc, pc_hold, busy});
        end
        proc_done = 1'b1;
        tick();
        proc_done = 1'b0;
        n_cmp++;
        if ({busy, cur_proc} !== {1'b0, 3'd5}) begin
            n_err++;
            $display("FAIL idle_cur_kept: got busy=%b cur=%0d expected 0/5", busy, cur_proc);
        end
    endtask

    task automatic test_reset_mid_switch();
        int pulses;
        cfg_write(3'd3, 32'h300, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_select: got busy=%b expected 1", busy);
        end
        Reset = 1'b0;
        #1;
        n_cmp++;
        if ({change_pc, exec_proc, pc_hold, busy, pc_in, cur_proc} !== {4'b0110, 32'h0, 3'd7}) begin
            n_err++;
            $display("FAIL async_reset: got ctl=%b pc_in=%h cur=%0d expected 0110/00000000/7",
                     {change_pc, exec_proc, pc_hold, busy}, pc_in, cur_proc);
        end
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (change_pc !== 1'b0) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_err++;
            $display("FAIL aborted_switch_pulse: got %0d pulses expected 0", pulses);
        end
        Reset = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL no_auto_resume: got busy=%b expected 0", busy);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n_cmp++;
        if ({change_pc, exec_proc, pc_hold, busy} !== 4'b0110) begin
            n_err++;
            $display("FAIL table_cleared: got %b expected 0110", {change_pc, exec_proc, pc_hold, busy});
        end
        cfg_write(3'd3, 32'h300, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n_cmp++;
        if ({change_pc, pc_in} !== {1'b1, 32'h300}) begin
            n_err++;
            $display("FAIL resume_load: got change_pc=%b pc_in=%h expected 1/00000300", change_pc, pc_in);
        end
        tick();
        n_cmp++;
        if ({exec_proc, busy, cur_proc} !== {1'b0, 1'b1, 3'd3}) begin
            n_err++;
            $display("FAIL resume_run: got exec=%b busy=%b cur=%0d expected 0/1/3", exec_proc, busy, cur_proc);
        end
    endtask

    initial begin
        Reset      = 1'b0;
        start      = 1'b0;
        cfg_we     = 1'b0;
        cfg_id     = 3'd0;
        cfg_pc     = 32'h0;
        cfg_valid  = 1'b0;
        quantum    = 5'd0;
        proc_done  = 1'b0;
        pc_counter = 5'd0;
        pc_out     = 32'h0;

        test_reset();
        test_first_dispatch();
        test_expiry();
        test_done_wins();
        test_cfg_clear_running();
        test_single_slot();
        test_quantum_zero();
        test_reset_mid_switch();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
